// File: rtl/video_pkg.sv
// Shared timing defaults, FSM encoding and raster total helpers for video_stream_tx.
// Pure declarations: no latency and no backpressure of its own.
package video_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int H_FP_DEF     = 48;
    localparam int H_SYNC_DEF   = 32;
    localparam int H_BP_DEF     = 80;
    localparam int V_ACTIVE_DEF = 720;
    localparam int V_FP_DEF     = 3;
    localparam int V_SYNC_DEF   = 5;
    localparam int V_BP_DEF     = 20;
    localparam int CNT_W_DEF    = 11;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Free-running h/v raster counters with region decode; decode is combinational from the counters.
// Counters advance every cycle while run_i is high and are held at zero otherwise; no backpressure.
module raster_counter
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run_i,
    output logic       act_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       last_o,
    output logic       first_o,
    output logic [7:0] pat_o
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign act_o   = (h_q < H_ACT) && (v_q < V_ACT);
    assign hsync_o = (h_q >= H_SS) && (h_q < H_SE);
    assign vsync_o = (v_q >= V_SS) && (v_q < V_SE);
    assign last_o  = (h_q == H_LAST) && (v_q == V_LAST);
    assign first_o = (h_q == '0) && (v_q == '0);
    assign pat_o   = 8'(h_q) + 8'(v_q);

endmodule

// File: rtl/video_stream_tx.sv
// Raster source: pulls luma from a valid/ready stream and emits y/dv/hs/vs one cycle after each counter position.
// Never stalls; a missing pixel in an active slot becomes 0 and sets sticky underflow. TEST_PATTERN_EN adds pat_sel.
module video_stream_tx
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
`ifdef TEST_PATTERN_EN
    input  logic       pat_sel,
`endif
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] y_o,
    output logic       dv_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       frame_done,
    output logic       underflow
);

    state_t     state_q, state_d;
    logic       run, act, hsync, vsync, last, first;
    logic [7:0] pix_pat;
    logic       pat_sel_w, pat_q, pat_use;
    logic [7:0] y_q;
    logic       dv_q, hs_q, vs_q, fd_q, uf_q;

    raster_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CNT_W(CNT_W)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .run_i   (run),
        .act_o   (act),
        .hsync_o (hsync),
        .vsync_o (vsync),
        .last_o  (last),
        .first_o (first),
        .pat_o   (pix_pat)
    );

`ifdef TEST_PATTERN_EN
    assign pat_sel_w = pat_sel;
`else
    assign pat_sel_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (last && !en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign run = (state_q == RUN);
    // Source choice latches at frame start so a frame never mixes pattern and stream pixels.
    assign pat_use = (run && first) ? pat_sel_w : pat_q;
    assign s_ready = run && act && !pat_use;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pat_q   <= 1'b0;
            y_q     <= '0;
            dv_q    <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            fd_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_use;
            dv_q    <= run && act;
            hs_q    <= run && hsync;
            vs_q    <= run && vsync;
            fd_q    <= run && last;
            uf_q    <= uf_q | (run && act && !pat_use && !s_valid);
            if (run && act)
                y_q <= pat_use ? pix_pat : (s_valid ? s_data : 8'h00);
            else
                y_q <= 8'h00;
        end
    end

    assign y_o        = y_q;
    assign dv_o       = dv_q;
    assign hs_o       = hs_q;
    assign vs_o       = vs_q;
    assign frame_done = fd_q;
    assign underflow  = uf_q;

endmodule
